// File: rtl/spi_master_write.sv
// SPI master issuing one framed transaction: an address byte {wr, adr} followed by an NBIT
// data word, MSB first, sclk idle low; read frames shift miso into rdata during the data field.
module spi_master_write #(
    parameter int NBIT     = 32,
    parameter int NBIT_ADR = 8,
    parameter int DIV      = 5,
    parameter int CS_SETUP = 10,
    parameter int GAP      = 1,
    parameter int CS_HOLD  = 10
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
    input  logic                wr,
    input  logic [NBIT_ADR-2:0] adr,
    input  logic [NBIT-1:0]     wdata,
    output logic                busy,
    output logic                done,
    output logic [NBIT-1:0]     rdata,
    output logic                sclk,
    output logic                mosi,
    output logic                cs,
    input  logic                miso
);

    localparam int DW    = $clog2(2 * DIV);
    localparam int BMAX  = (NBIT > NBIT_ADR) ? NBIT : NBIT_ADR;
    localparam int BW    = $clog2(BMAX + 1);
    localparam int PMAX0 = (CS_SETUP > GAP) ? CS_SETUP : GAP;
    localparam int PMAX  = (PMAX0 > CS_HOLD) ? PMAX0 : CS_HOLD;
    localparam int PW    = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(2 * DIV - 1);
    localparam logic [DW-1:0] DIV_HALF   = DW'(DIV);
    localparam logic [BW-1:0] ADR_LAST   = BW'(NBIT_ADR - 1);
    localparam logic [BW-1:0] DAT_LAST   = BW'(NBIT - 1);
    localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] GAP_LAST   = PW'(GAP - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ADR,
        S_GAP,
        S_DATA,
        S_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [PW-1:0]         ph_q, ph_d;
    logic                  wr_q, wr_d;
    logic [NBIT-1:0]       rdata_q, rdata_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_q, cs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [NBIT_ADR-1:0]   adr_sr_q, adr_sr_d;
    logic [NBIT-1:0]       dat_sr_q, dat_sr_d;
    logic [NBIT-1:0]       rx_q, rx_d;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        ph_d     = ph_q;
        wr_d     = wr_q;
        rdata_d  = rdata_q;
        adr_sr_d = adr_sr_q;
        dat_sr_d = dat_sr_q;
        rx_d     = rx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    adr_sr_d = {wr, adr};
                    dat_sr_d = wdata;
                    wr_d     = wr;
                    div_d    = '0;
                    bit_d    = '0;
                    ph_d     = '0;
                    state_d  = (CS_SETUP > 0) ? S_SETUP : S_ADR;
                end
            end
            S_SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    ph_d    = '0;
                    state_d = S_ADR;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_ADR: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    adr_sr_d = {adr_sr_q[NBIT_ADR-2:0], 1'b0};
                    if (bit_q == ADR_LAST) begin
                        bit_d   = '0;
                        state_d = (GAP > 0) ? S_GAP : S_DATA;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_GAP: begin
                if (ph_q == GAP_LAST) begin
                    ph_d    = '0;
                    state_d = S_DATA;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    dat_sr_d = {dat_sr_q[NBIT-2:0], 1'b0};
                    if (bit_q == DAT_LAST) begin
                        bit_d   = '0;
                        state_d = (CS_HOLD > 0) ? S_HOLD : S_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    ph_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin registers are loaded from the next state so the pins line up with the phase they belong to.
        sclk_d = ((state_d == S_ADR) || (state_d == S_DATA)) && (div_d >= DIV_HALF);
        case (state_d)
            S_ADR:   mosi_d = adr_sr_d[NBIT_ADR-1];
            S_GAP:   mosi_d = mosi_q;
            S_DATA:  mosi_d = wr_d & dat_sr_d[NBIT-1];
            default: mosi_d = 1'b1;
        endcase
        cs_d   = (state_d == S_IDLE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_q != S_IDLE) && (state_d == S_IDLE);

        // miso is taken on the same edge that registers the sclk rise, i.e. where the slave samples mosi.
        if ((state_d == S_DATA) && sclk_d && !sclk_q) begin
            rx_d = {rx_q[NBIT-2:0], miso};
        end
        if (done_d && !wr_q) begin
            rdata_d = rx_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        adr_sr_q <= adr_sr_d;
        dat_sr_q <= dat_sr_d;
        rx_q     <= rx_d;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign cs    = cs_q;

endmodule

// File: tb/tb_spi_master_write.sv
// Bench for spi_master_write: a default-parameter instance and a fast instance (DIV=1, no
// setup/gap/hold), each observed by a bus monitor with a register-slave model and a miso source.
module tb_spi_master_write;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstb;
    logic [1:0]          start_w, wr_w, miso_w;
    logic [1:0][6:0]     adr_w;
    logic [1:0][31:0]    wdata_w;
    logic [1:0]          busy_w, done_w, sclk_w, mosi_w, cs_w;
    logic [1:0][31:0]    rdata_w;

    spi_master_write u_dut (
        .clk(clk), .rstb(rstb), .start(start_w[0]), .wr(wr_w[0]), .adr(adr_w[0]),
        .wdata(wdata_w[0]), .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]),
        .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs(cs_w[0]), .miso(miso_w[0])
    );

    spi_master_write #(.DIV(1), .CS_SETUP(0), .GAP(0), .CS_HOLD(0)) u_dut_fast (
        .clk(clk), .rstb(rstb), .start(start_w[1]), .wr(wr_w[1]), .adr(adr_w[1]),
        .wdata(wdata_w[1]), .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]),
        .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs(cs_w[1]), .miso(miso_w[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Bus monitor state, one slot per instance
    logic        prev_cs[2]   = '{1'b1, 1'b1};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    int          cs_low_cnt[2], frame_len[2], nbits[2], last_nbits[2];
    int          fall_cnt[2], toggles[2], frame_toggles[2];
    int          frames[2], dones[2], gap_cnt[2], last_gap[2];
    logic [63:0] sh[2], last_bits[2];
    logic [31:0] slave_out[2];
    logic [31:0] rd_word[2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_w[k]) dones[k]++;
            if (!cs_w[k]) begin
                if (prev_cs[k]) begin
                    last_gap[k]   = gap_cnt[k];
                    cs_low_cnt[k] = 0;
                    nbits[k]      = 0;
                    sh[k]         = '0;
                    fall_cnt[k]   = 0;
                    toggles[k]    = 0;
                    miso_w[k]     = 1'b0;
                end else if (sclk_w[k] != prev_sclk[k]) begin
                    toggles[k]++;
                end
                cs_low_cnt[k]++;
                if (sclk_w[k] && !prev_sclk[k]) begin
                    sh[k] = {sh[k][62:0], mosi_w[k]};
                    nbits[k]++;
                end
                if (!sclk_w[k] && prev_sclk[k]) begin
                    fall_cnt[k]++;
                    if (fall_cnt[k] >= 8 && fall_cnt[k] < 40)
                        miso_w[k] = rd_word[k][5'(39 - fall_cnt[k])];
                end
            end else begin
                if (!prev_cs[k]) begin
                    frame_len[k]     = cs_low_cnt[k];
                    last_bits[k]     = sh[k];
                    last_nbits[k]    = nbits[k];
                    frame_toggles[k] = toggles[k];
                    frames[k]++;
                    gap_cnt[k]       = 0;
                    if (nbits[k] == 40 && sh[k][39] && sh[k][38:32] == 7'h01)
                        slave_out[k] = sh[k][31:0];
                end
                gap_cnt[k]++;
                miso_w[k] = 1'b0;
            end
            prev_cs[k]   = cs_w[k];
            prev_sclk[k] = sclk_w[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int k, input logic w, input logic [6:0] a, input logic [31:0] d,
                             input logic [31:0] rw, output logic seen, output logic [31:0] rd_done);
        @(negedge clk);
        wr_w[k] = w; adr_w[k] = a; wdata_w[k] = d; rd_word[k] = rw; start_w[k] = 1'b1;
        @(negedge clk);
        start_w[k] = 1'b0; wr_w[k] = ~w; adr_w[k] = ~a; wdata_w[k] = ~d;
        seen = 1'b0;
        rd_done = '0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done_w[k]) begin
                seen = 1'b1;
                rd_done = rdata_w[k];
            end
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  adr;
        logic [31:0] wdata;
        logic [31:0] rdword;
        logic [7:0]  e_adr;
        logic [31:0] e_data;
        logic [31:0] e_slave;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic        seen, seen2;
        logic [31:0] rdd;
        logic [63:0] bits;
        int          d0, f0;

        vecs[0] = '{1'b1, 7'h01, 32'hDEEDBEEF, 32'h0,        8'h81, 32'hDEEDBEEF, 32'hDEEDBEEF, 32'h0};
        vecs[1] = '{1'b1, 7'h02, 32'hABCDEF01, 32'h0,        8'h82, 32'hABCDEF01, 32'hDEEDBEEF, 32'h0};
        vecs[2] = '{1'b1, 7'h01, 32'h23CDEF01, 32'h0,        8'h81, 32'h23CDEF01, 32'h23CDEF01, 32'h0};
        vecs[3] = '{1'b0, 7'h05, 32'hFFFFFFFF, 32'h12345678, 8'h05, 32'h0,        32'h23CDEF01, 32'h12345678};
        vecs[4] = '{1'b1, 7'h7F, 32'h00000000, 32'h0,        8'hFF, 32'h0,        32'h23CDEF01, 32'h12345678};
        vecs[5] = '{1'b0, 7'h7F, 32'h00000000, 32'hA5A55A5A, 8'h7F, 32'h0,        32'h23CDEF01, 32'hA5A55A5A};

        rstb = 1'b0;
        start_w = '0; wr_w = '0; adr_w = '0; wdata_w = '0;
        rd_word[0] = '0; rd_word[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_cs", k),    64'(cs_w[k]),    64'd1);
            chk($sformatf("rst%0d_sclk", k),  64'(sclk_w[k]),  64'd0);
            chk($sformatf("rst%0d_mosi", k),  64'(mosi_w[k]),  64'd1);
            chk($sformatf("rst%0d_busy", k),  64'(busy_w[k]),  64'd0);
            chk($sformatf("rst%0d_done", k),  64'(done_w[k]),  64'd0);
            chk($sformatf("rst%0d_rdata", k), 64'(rdata_w[k]), 64'd0);
        end
        rstb = 1'b1;

        // Table: write, address-miss write, second write, reads and an all-ones address byte
        for (int i = 0; i < 6; i++) begin
            d0 = dones[0];
            run_frame(0, vecs[i].wr, vecs[i].adr, vecs[i].wdata, vecs[i].rdword, seen, rdd);
            bits = last_bits[0];
            chk($sformatf("v%0d_done_seen", i),  64'(seen), 64'd1);
            chk($sformatf("v%0d_done_count", i), 64'(dones[0] - d0), 64'd1);
            chk($sformatf("v%0d_cs_low_len", i), 64'(frame_len[0]), 64'd421);
            chk($sformatf("v%0d_bit_count", i),  64'(last_nbits[0]), 64'd40);
            chk($sformatf("v%0d_adr_byte", i),   64'(bits[39:32]), 64'(vecs[i].e_adr));
            chk($sformatf("v%0d_data_word", i),  64'(bits[31:0]), 64'(vecs[i].e_data));
            chk($sformatf("v%0d_slave_out", i),  64'(slave_out[0]), 64'(vecs[i].e_slave));
            chk($sformatf("v%0d_rdata_done", i), 64'(rdd), 64'(vecs[i].e_rdata));
            chk($sformatf("v%0d_busy_after", i), 64'(busy_w[0]), 64'd0);
        end

        // start pulsed mid-address is dropped
        d0 = dones[0]; f0 = frames[0];
        @(negedge clk);
        wr_w[0] = 1'b1; adr_w[0] = 7'h01; wdata_w[0] = 32'h11112222; start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (30) @(negedge clk);
        wdata_w[0] = 32'h99999999; start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        repeat (20) @(negedge clk);
        chk("midadr_done_seen",  64'(seen), 64'd1);
        chk("midadr_done_count", 64'(dones[0] - d0), 64'd1);
        chk("midadr_frames",     64'(frames[0] - f0), 64'd1);
        chk("midadr_slave_out",  64'(slave_out[0]), 64'h11112222);
        chk("midadr_cs_idle",    64'(cs_w[0]), 64'd1);

        // start held through the done cycle launches a back-to-back frame
        d0 = dones[0]; f0 = frames[0];
        @(negedge clk);
        wr_w[0] = 1'b1; adr_w[0] = 7'h01; wdata_w[0] = 32'h5555AAAA; start_w[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done_w[0]) seen = 1'b1;
        end
        wdata_w[0] = 32'h6666BBBB;
        @(negedge clk);
        start_w[0] = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 3000 && !seen2; i++) begin
            @(negedge clk);
            if (done_w[0]) seen2 = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("b2b_done1_seen",  64'(seen), 64'd1);
        chk("b2b_done2_seen",  64'(seen2), 64'd1);
        chk("b2b_done_count",  64'(dones[0] - d0), 64'd2);
        chk("b2b_frames",      64'(frames[0] - f0), 64'd2);
        chk("b2b_cs_high_gap", 64'(last_gap[0]), 64'd1);
        chk("b2b_cs_low_len",  64'(frame_len[0]), 64'd421);
        chk("b2b_slave_out",   64'(slave_out[0]), 64'h6666BBBB);

        // Reset in the 10th data bit aborts the frame
        d0 = dones[0];
        @(negedge clk);
        wr_w[0] = 1'b1; adr_w[0] = 7'h01; wdata_w[0] = 32'h0F0F0F0F; start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (nbits[0] >= 18 && !cs_w[0]) seen = 1'b1;
        end
        chk("abort_point_reached", 64'(seen), 64'd1);
        rstb = 1'b0;
        #1;
        chk("abort_cs",    64'(cs_w[0]), 64'd1);
        chk("abort_sclk",  64'(sclk_w[0]), 64'd0);
        chk("abort_mosi",  64'(mosi_w[0]), 64'd1);
        chk("abort_busy",  64'(busy_w[0]), 64'd0);
        chk("abort_rdata", 64'(rdata_w[0]), 64'd0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_done",   64'(dones[0] - d0), 64'd0);
        chk("abort_slave_out", 64'(slave_out[0]), 64'h6666BBBB);
        d0 = dones[0];
        run_frame(0, 1'b1, 7'h01, 32'hCAFEF00D, 32'h0, seen, rdd);
        chk("post_abort_done_seen",  64'(seen), 64'd1);
        chk("post_abort_done_count", 64'(dones[0] - d0), 64'd1);
        chk("post_abort_cs_low_len", 64'(frame_len[0]), 64'd421);
        chk("post_abort_bit_count",  64'(last_nbits[0]), 64'd40);
        chk("post_abort_slave_out",  64'(slave_out[0]), 64'hCAFEF00D);

        // Fast instance: sclk toggles every clk, 80-cycle frame
        d0 = dones[1];
        run_frame(1, 1'b1, 7'h01, 32'h3C3CA5A5, 32'h0, seen, rdd);
        bits = last_bits[1];
        chk("fast_done_seen",  64'(seen), 64'd1);
        chk("fast_done_count", 64'(dones[1] - d0), 64'd1);
        chk("fast_cs_low_len", 64'(frame_len[1]), 64'd80);
        chk("fast_toggles",    64'(frame_toggles[1]), 64'd79);
        chk("fast_adr_byte",   64'(bits[39:32]), 64'h81);
        chk("fast_data_word",  64'(bits[31:0]), 64'h3C3CA5A5);
        chk("fast_slave_out",  64'(slave_out[1]), 64'h3C3CA5A5);
        chk("fast_rdata",      64'(rdd), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
